// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the dual-slot memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  // Arbiter FSM: IDLE issues at most one slot; SECOND drains the held C slot
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } arb_state_e;

  // Word index lives in addr[WORD_MSB:WORD_LSB]; the bits below it must be 0
  localparam int WORD_LSB    = 2;
  localparam int WORD_MSB    = 5;
  localparam int STALL_CNT_W = 16;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Request/response bundle between the two-slot pipeline and the
//               single-ported data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;

  // Slot requests from the pipeline
  logic        req_valid_a;
  logic        req_we_a;
  logic [31:0] req_addr_a;
  logic [31:0] req_wdata_a;
  logic        req_valid_c;
  logic        req_we_c;
  logic [31:0] req_addr_c;
  logic [31:0] req_wdata_c;

  // Pipeline hold
  logic        stall;

  // Data-memory side
  logic        MemRd;
  logic        MemWr;
  logic        MemRdComp;
  logic        MemWrComp;
  logic [31:0] dm_addr;
  logic [31:0] dm_addr_c;
  logic [31:0] dm_in;
  logic [31:0] DM_out;

  // Load results and status
  logic [31:0] rdata_a;
  logic [31:0] rdata_c;
  logic        rvalid_a;
  logic        rvalid_c;
  logic        misalign;
  logic [15:0] stall_cnt;

  // Arbiter view
  modport slave (
    input  req_valid_a, req_we_a, req_addr_a, req_wdata_a,
    input  req_valid_c, req_we_c, req_addr_c, req_wdata_c,
    input  DM_out,
    output stall,
    output MemRd, MemWr, MemRdComp, MemWrComp,
    output dm_addr, dm_addr_c, dm_in,
    output rdata_a, rdata_c, rvalid_a, rvalid_c,
    output misalign, stall_cnt
  );

  // Pipeline / memory-model view
  modport master (
    output req_valid_a, req_we_a, req_addr_a, req_wdata_a,
    output req_valid_c, req_we_c, req_addr_c, req_wdata_c,
    output DM_out,
    input  stall,
    input  MemRd, MemWr, MemRdComp, MemWrComp,
    input  dm_addr, dm_addr_c, dm_in,
    input  rdata_a, rdata_c, rvalid_a, rvalid_c,
    input  misalign, stall_cnt
  );

endinterface : mem_arbiter_if
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Serialises the main (A) and companion (C) pipeline slots onto
//               one data-memory port. A dual request issues A first with a
//               one-cycle stall, then C from a held copy, which keeps program
//               order for A-store / C-load hazards to the same word.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  localparam logic [STALL_CNT_W-1:0] c_stall_max = '1;

  arb_state_e              r_state;
  logic                    r_we_c;
  logic [31:0]             r_addr_c;
  logic [31:0]             r_wdata_c;
  logic [31:0]             r_rdata_a;
  logic [31:0]             r_rdata_c;
  logic                    r_rvalid_a;
  logic                    r_rvalid_c;
  logic                    r_misalign;
  logic [STALL_CNT_W-1:0]  r_stall_cnt;

  logic        w_a_ok;
  logic        w_c_ok;
  logic        w_a_mis;
  logic        w_c_mis;
  logic        w_issue_a;
  logic        w_issue_c;
  logic        w_we;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_stall;

  // Misaligned requests are dropped up front so they never claim a cycle
  assign w_a_ok  = bus.req_valid_a & (bus.req_addr_a[WORD_LSB-1:0] == '0);
  assign w_c_ok  = bus.req_valid_c & (bus.req_addr_c[WORD_LSB-1:0] == '0);
  assign w_a_mis = bus.req_valid_a & ~w_a_ok;
  assign w_c_mis = bus.req_valid_c & ~w_c_ok;

  // Issue mux: pick the slot owning the memory port this cycle (nothing in reset)
  always_comb begin
    w_issue_a = 1'b0;
    w_issue_c = 1'b0;
    w_we      = 1'b0;
    w_addr    = '0;
    w_wdata   = '0;
    w_stall   = 1'b0;
    if (reset) begin
      if (r_state == SECOND) begin
        w_issue_c = 1'b1;
        w_we      = r_we_c;
        w_addr    = r_addr_c;
        w_wdata   = r_wdata_c;
      end else if (w_a_ok) begin
        w_issue_a = 1'b1;
        w_we      = bus.req_we_a;
        w_addr    = bus.req_addr_a;
        w_wdata   = bus.req_wdata_a;
        w_stall   = w_c_ok;
      end else if (w_c_ok) begin
        w_issue_c = 1'b1;
        w_we      = bus.req_we_c;
        w_addr    = bus.req_addr_c;
        w_wdata   = bus.req_wdata_c;
      end
    end
  end

  assign bus.stall     = w_stall;
  assign bus.MemRd     = w_issue_a & ~w_we;
  assign bus.MemWr     = w_issue_a &  w_we;
  assign bus.MemRdComp = w_issue_c & ~w_we;
  assign bus.MemWrComp = w_issue_c &  w_we;
  assign bus.dm_addr   = w_addr;
  assign bus.dm_addr_c = w_addr;
  assign bus.dm_in     = w_wdata;

  // FSM, held C request, load capture, misalign pulse and stall counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_we_c      <= 1'b0;
      r_addr_c    <= '0;
      r_wdata_c   <= '0;
      r_rdata_a   <= '0;
      r_rdata_c   <= '0;
      r_rvalid_a  <= 1'b0;
      r_rvalid_c  <= 1'b0;
      r_misalign  <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_rvalid_a <= w_issue_a & ~w_we;
      r_rvalid_c <= w_issue_c & ~w_we;
      if (w_issue_a && !w_we) begin
        r_rdata_a <= bus.DM_out;
      end
      if (w_issue_c && !w_we) begin
        r_rdata_c <= bus.DM_out;
      end
      r_misalign <= (r_state == IDLE) & (w_a_mis | w_c_mis);
      if (w_stall && (r_stall_cnt != c_stall_max)) begin
        r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
      end
      case (r_state)
        IDLE: begin
          if (w_stall) begin
            r_state   <= SECOND;
            r_we_c    <= bus.req_we_c;
            r_addr_c  <= bus.req_addr_c;
            r_wdata_c <= bus.req_wdata_c;
          end
        end
        SECOND:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rdata_a   = r_rdata_a;
  assign bus.rdata_c   = r_rdata_c;
  assign bus.rvalid_a  = r_rvalid_a;
  assign bus.rvalid_c  = r_rvalid_c;
  assign bus.misalign  = r_misalign;
  assign bus.stall_cnt = r_stall_cnt;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed bench for mem_arbiter with a 16-word memory model and
//               a queue-based scoreboard for load results and misalign pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_a_q[$];
  logic [31:0] exp_c_q[$];
  int          exp_mis = 0;

  // Memory contents restored on every reset
  function automatic logic [31:0] init_word(input int i);
    case (i)
      0:       return 32'd12;
      1:       return 32'd32;
      3:       return 32'd5;
      12:      return 32'd17;
      default: return 32'h100 * i + 32'd7;
    endcase
  endfunction

  logic [31:0] mem [16];

  // Data memory: combinational read, write on posedge
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
    end else if (bus.MemWr || bus.MemWrComp) begin
      mem[bus.dm_addr[5:2]] <= bus.dm_in;
    end
  end
  assign bus.DM_out = mem[bus.dm_addr[5:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // {stall, MemRd, MemWr, MemRdComp, MemWrComp}
  function automatic logic [4:0] strb();
    return {bus.stall, bus.MemRd, bus.MemWr, bus.MemRdComp, bus.MemWrComp};
  endfunction

  task automatic drive(input logic va, input logic wea, input logic [31:0] aa, input logic [31:0] da,
                       input logic vc, input logic wec, input logic [31:0] ac, input logic [31:0] dc);
    bus.req_valid_a = va;  bus.req_we_a = wea;  bus.req_addr_a = aa;  bus.req_wdata_a = da;
    bus.req_valid_c = vc;  bus.req_we_c = wec;  bus.req_addr_c = ac;  bus.req_wdata_c = dc;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expected results whenever the DUT presents one
  always @(negedge clk) begin
    if (bus.rvalid_a) begin
      if (exp_a_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL rvalid_a_unexpected: rdata_a=%h with no load pending", bus.rdata_a);
      end else begin
        chk("rdata_a", bus.rdata_a, exp_a_q.pop_front());
      end
    end
    if (bus.rvalid_c) begin
      if (exp_c_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL rvalid_c_unexpected: rdata_c=%h with no load pending", bus.rdata_c);
      end else begin
        chk("rdata_c", bus.rdata_c, exp_c_q.pop_front());
      end
    end
    if (bus.misalign) begin
      n_checks++;
      if (exp_mis == 0) begin
        n_errors++;
        $display("FAIL misalign_unexpected: misalign=1 expected 0 at %0t", $time);
      end else begin
        exp_mis--;
      end
    end
    if (bus.MemRd || bus.MemWr || bus.MemRdComp || bus.MemWrComp) begin
      chk("one_strobe", 32'($countones({bus.MemRd, bus.MemWr, bus.MemRdComp, bus.MemWrComp})), 32'd1);
    end
  end

  // Watchdog
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h4, 32'h77);
    @(negedge clk);
    chk("strobes_in_reset", 32'(strb()), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    idle();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_rdata_a", bus.rdata_a, 32'h0);
    chk("rst_rdata_c", bus.rdata_c, 32'h0);
    chk("rst_rvalid", 32'({bus.rvalid_a, bus.rvalid_c}), 32'h0);
    chk("rst_misalign", 32'(bus.misalign), 32'h0);
    chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'h0);

    // Single A load from word 1
    step();
    drive(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    exp_a_q.push_back(32'd32);
    @(negedge clk);
    chk("t1_strobes", 32'(strb()), 32'b01000);
    chk("t1_dm_addr", bus.dm_addr, 32'h4);
    chk("t1_dm_addr_c", bus.dm_addr_c, 32'h4);
    step();
    idle();

    // A store then C load to the same word: RAW through the stall
    drive(1'b1, 1'b1, 32'h8, 32'd99, 1'b1, 1'b0, 32'h8, 32'h0);
    @(negedge clk);
    chk("t2_strobes_1", 32'(strb()), 32'b10100);
    chk("t2_dm_in", bus.dm_in, 32'd99);
    step();
    exp_c_q.push_back(32'd99);
    @(negedge clk);
    chk("t2_strobes_2", 32'(strb()), 32'b00010);
    chk("t2_dm_addr_c", bus.dm_addr_c, 32'h8);
    step();
    idle();
    @(negedge clk);
    chk("t2_stall_cnt", 32'(bus.stall_cnt), 32'd1);
    chk("t2_idle_strobes", 32'(strb()), 32'h0);
    chk("t2_idle_bus", bus.dm_addr | bus.dm_addr_c | bus.dm_in, 32'h0);

    // Dual loads: A word 0, C word 12
    step();
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0);
    exp_a_q.push_back(32'd12);
    @(negedge clk);
    chk("t3_strobes_1", 32'(strb()), 32'b11000);
    step();
    exp_c_q.push_back(32'd17);
    @(negedge clk);
    chk("t3_strobes_2", 32'(strb()), 32'b00010);
    chk("t3_dm_addr", bus.dm_addr, 32'h30);
    step();
    idle();
    @(negedge clk);
    chk("t3_stall_cnt", 32'(bus.stall_cnt), 32'd2);

    // Misaligned C store with aligned A load: no stall, A only
    step();
    drive(1'b1, 1'b0, 32'hC, 32'h0, 1'b1, 1'b1, 32'h6, 32'h55);
    exp_a_q.push_back(32'd5);
    exp_mis++;
    @(negedge clk);
    chk("t4_strobes", 32'(strb()), 32'b01000);
    step();
    idle();
    @(negedge clk);
    chk("t4_stall_cnt", 32'(bus.stall_cnt), 32'd2);

    // Upper address bits alias: store via 0x44, read back via 0x4 on slot C
    step();
    drive(1'b1, 1'b1, 32'h44, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t5_strobes_1", 32'(strb()), 32'b00100);
    chk("t5_dm_addr", bus.dm_addr, 32'h44);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
    exp_c_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    chk("t5_strobes_2", 32'(strb()), 32'b00010);
    step();
    idle();

    // Reset while SECOND is pending: held C store must be dropped
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h4, 32'h77);
    exp_a_q.push_back(32'd12);
    @(negedge clk);
    chk("t6_strobes_1", 32'(strb()), 32'b11000);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("t6_strobes_rst", 32'(strb()), 32'h0);
    step();
    reset = 1'b1;
    idle();
    @(negedge clk);
    chk("t6_stall_cnt", 32'(bus.stall_cnt), 32'h0);
    chk("t6_rvalid_c", 32'(bus.rvalid_c), 32'h0);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
    exp_c_q.push_back(32'd32);
    @(negedge clk);
    chk("t6_idle_after_rst", 32'(strb()), 32'b00010);
    step();
    idle();
    repeat (2) step();

    // Stall counter saturation with back-to-back dual stores
    drive(1'b1, 1'b1, 32'h10, 32'h1, 1'b1, 1'b1, 32'h14, 32'h2);
    repeat (2 * 65534) @(posedge clk);
    @(negedge clk);
    chk("sat_fffe", 32'(bus.stall_cnt), 32'h0000FFFE);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("sat_ffff", 32'(bus.stall_cnt), 32'h0000FFFF);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("sat_hold", 32'(bus.stall_cnt), 32'h0000FFFF);
    step();
    idle();
    repeat (3) step();

    chk("pending_a", 32'(exp_a_q.size()), 32'h0);
    chk("pending_c", 32'(exp_c_q.size()), 32'h0);
    chk("pending_mis", 32'(exp_mis), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_mem_arbiter
`default_nettype wire
